mem_ctrl: RTL
=============

# mem_ctrl

Multicycle word memory with a valid/ready request port and a one-cycle response pulse; it replaces the zero-latency data memory in front of the multicycle CPU. The CPU control FSM issues one instruction fetch or data access at a time and stalls in its current state until `resp_valid`. Latency is a parameter, so the same CPU runs against slow or fast memory models. Misaligned and out-of-range accesses are flagged instead of aliasing.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `LATENCY`, 3: number of clock edges in WAIT before the access completes; legal range 1..15.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  controller can accept a request (high exactly when in IDLE).
- `req_we`  input  1  1 = write, 0 = read.
- `req_addr`  input  32  byte address; bits [1:0] must be 0.
- `req_wdata`  input  32  write data.
- `resp_valid`  output  1  one-cycle pulse: access complete.
- `resp_rdata`  output  32  read data; held until the next response.
- `resp_err`  output  1  error flag for the current response; held with `resp_rdata`.

## Operation
- States: IDLE, WAIT. A 4-bit down-counter `cnt` is used in WAIT.
- IDLE: `req_ready`=1. When `req_valid`=1 at a rising edge:
  - latch `req_we`, `req_addr`, `req_wdata`;
  - load `cnt` = LATENCY-1;
  - go to WAIT.
- Inputs are ignored outside that accept edge. Later changes to `req_*` never affect an accepted access.
- WAIT: `req_ready`=0.
  - At each edge where `cnt`≠0: `cnt` decrements.
  - At the edge where `cnt`=0: perform the access, set `resp_valid`=1 for the next cycle, return to IDLE.
- Error condition, evaluated on the latched address: `addr[1:0]`≠0 or `addr[31:2]` ≥ DEPTH_WORDS.
- Completion without error:
  - read: `resp_rdata` = mem[addr[31:2]];
  - write: mem[addr[31:2]] = wdata, and `resp_rdata` = wdata;
  - `resp_err`=0.
- Completion with error: no memory write, `resp_rdata`=0, `resp_err`=1.
- Memory array is not cleared by reset; contents are X until written (simulation may preload). Reads never modify memory.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `cnt`=0.
- Reset takes effect immediately, asynchronously. Deassertion is used synchronously at the next edge.
- Latency: request accepted at edge N completes at edge N+LATENCY. `resp_valid` is high for the single cycle between edges N+LATENCY and N+LATENCY+1.
- Back-to-back requests: the response cycle is an IDLE cycle with `req_ready`=1. A request held during it is accepted at edge N+LATENCY+1. Minimum request spacing is LATENCY+1 edges.
- Write commit happens at the completion edge. A read accepted afterwards, including the very next request, returns the new data.
- `resp_valid` never stays high for two consecutive cycles.
- Reset during WAIT: the access is dropped, no memory write occurs, no `resp_valid` is produced, and the controller returns to IDLE.
- `req_valid`=1 while `req_ready`=0 is permitted. It has no effect and is not queued.
- LATENCY=1 is legal. There is one WAIT cycle, so `resp_valid` appears 1 edge after accept.

## Test plan
- Reset: with `rst_n`=0 asynchronously mid-cycle -> `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0 before the next edge.
- Write then read, LATENCY=3:
  - write addr 0x10, data 0xDEADBEEF, accepted edge 1 -> `resp_valid` only after edge 4, `resp_err`=0;
  - read 0x10 accepted edge 5 -> `resp_valid` after edge 8, `resp_rdata`=0xDEADBEEF;
  - `req_ready`=0 after edge 1 through edge 4.
- Errors:
  - read 0x12 -> `resp_err`=1, `resp_rdata`=0;
  - write 0x1000 with DEPTH_WORDS=1024 -> `resp_err`=1, and a subsequent read of 0x0 returns its prior value unchanged.
- Back-to-back and input stability: hold `req_valid`=1 with writes to 0x0 (0x1), 0x4 (0x2), and a read of 0x4 -> responses spaced exactly 4 edges apart, read returns 0x2. Toggling `req_addr` during WAIT does not change the result.
- Reset mid-operation: write 0x8 = 0x55 accepted, assert `rst_n`=0 one edge later -> no `resp_valid`; after release, a read of 0x8 returns its pre-write value.
- LATENCY=1 build: read accepted edge N -> `resp_valid` after edge N+1; a second request accepted at edge N+2 -> response after edge N+3.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request/response bus between the CPU and mem_ctrl
interface mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - multicycle word memory with parameterised latency
// and flagged misaligned/out-of-range accesses.
module mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_ctrl_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             addr_err;
    logic             done;
    logic             mem_we;
    logic [IDX_W-1:0] idx;

    // Everything is judged on the latched request so late bus changes cannot leak in.
    assign idx      = addr_q[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
    assign done     = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we   = done && we_q && !addr_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (state_q == IDLE) begin
            if (bus.req_valid) begin
                we_d    = bus.req_we;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                cnt_d   = 4'(LATENCY - 1);
                state_d = WAIT;
            end
        end else begin
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                if (addr_err) begin
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b1;
                end else begin
                    resp_rdata_d = we_q ? wdata_q : mem[idx];
                    resp_err_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Reset forces state_q to IDLE immediately, so an in-flight write can never commit.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule
